dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Sequencer that drives the frequency and phase control words of the DDS phase accumulator. It performs programmable linear frequency sweeps: single pass, repeating sawtooth, or triangle. Each frequency point is held for a programmable dwell time. A one-cycle phase-offset pulse is issued at sweep start. Configuration is loaded through a valid/ready handshake; start and abort are single-cycle strobes.

Parameters:
W, 8, width of frq_ctrl/pha_ctrl and all frequency config fields
DWELL_W, 16, width of dwell counter and cfg_dwell

Ports:
clk_100m  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  config offered
cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
cfg_start_frq  in  W  first sweep frequency word
cfg_stop_frq  in  W  last sweep frequency word
cfg_step  in  W  frequency increment per point
cfg_dwell  in  DWELL_W  extra hold cycles per point (hold = cfg_dwell+1)
cfg_mode  in  2  0=single, 1=repeat, 2=triangle, 3=reserved (treated as single)
cfg_pha  in  W  phase offset pulsed at sweep start
start  in  1  begin sweep (honoured in IDLE only)
abort  in  1  terminate sweep
frq_ctrl  out  W  frequency control word to accumulator
pha_ctrl  out  W  phase control word to accumulator
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at single-sweep completion

Behaviour:
- Clock is clk_100m; reset is synchronous and active-high. All outputs are registered.
- Reset values: frq_ctrl=0, pha_ctrl=0, busy=0, done=0, cfg_ready=1. State is IDLE. Config registers are all zero. Direction is up.
- States: IDLE, DWELL, DONE.
- cfg_ready=1 only in IDLE. A handshake in IDLE latches all cfg_* fields. cfg_valid outside IDLE is ignored; no latch occurs.
- start in IDLE at cycle T:
  - T+1: frq_ctrl=start_frq, pha_ctrl=cfg_pha, busy=1, dwell counter=cfg_dwell, state DWELL.
  - T+2: pha_ctrl=0. It stays 0 for the rest of the sweep, because the accumulator adds pha_ctrl every cycle.
- start and a config handshake in the same IDLE cycle: the new config is latched and used for this sweep.
- DWELL: the counter decrements each cycle. While counter≠0, frq_ctrl is held. When counter==0, the next point is computed and driven the following cycle, and the counter reloads cfg_dwell. Each point is therefore held exactly cfg_dwell+1 cycles.
- Next-point arithmetic uses W+1 bits; frq_ctrl never wraps.
  - Up: sum=frq+step. If sum≥stop, the next point is stop and is the final up point.
  - Down (triangle only): diff=frq-step. If it borrows or diff≤start, the next point is start and is the final down point.
- End of final up point's dwell:
  - single: go to DONE. frq_ctrl holds stop, busy=0, done=1 for one cycle, then IDLE. frq_ctrl keeps stop until the next start or abort.
  - repeat: the next point is start_frq. pha_ctrl is not re-pulsed.
  - triangle: direction flips to down; the next point is stop-step, clamped per the rule above.
- End of final down point's dwell (triangle): direction flips to up; the next point is start+step, clamped.
- Degenerate configs:
  - start_frq≥stop_frq or step=0: the sweep is a single point at start_frq.
  - single mode: done after cfg_dwell+1 cycles.
  - repeat/triangle: the point is held indefinitely until abort.
- Repeat and triangle never assert done; they run until abort.
- abort (any state, highest priority after rst): next cycle state=IDLE, frq_ctrl=0, pha_ctrl=0, busy=0, done=0, direction=up. Latched config is retained.
- abort and start in the same IDLE cycle: abort wins and no sweep starts.
- start while busy is ignored.
- rst mid-sweep: identical to reset values next cycle, and config is cleared.

Decomposition:
- Package dds_pkg holds:
  - mode typedef/constants MODE_SINGLE, MODE_REPEAT, MODE_TRI
  - state typedef (IDLE/DWELL/DONE)
  - default W and DWELL_W
- One sub-module, dds_dwell_timer: a loadable down-counter with sync reset, a load input, and a zero flag.
- Next-point arithmetic and the FSM stay in the top module.

Test Plan:
- Single sweep: start=10, stop=40, step=10, dwell=2, mode=0.
  - frq_ctrl is 10,10,10,20,20,20,30,30,30,40,40,40 on T+1..T+12.
  - pha_ctrl=cfg_pha (e.g. 64) only at T+1.
  - done=1 only at T+13; busy falls at T+13.
- Clamp, no wrap: start=250, stop=255, step=4, dwell=0, mode=0 -> 250,254,255, then done. frq_ctrl never shows a wrapped value.
- Triangle: start=10, stop=30, step=10, dwell=0, mode=2 -> 10,20,30,20,10,20,30,... for ≥3 periods with no done. Abort -> frq_ctrl=0, busy=0 next cycle.
- Repeat: start=5, stop=15, step=5, dwell=1, mode=1 -> 5,5,10,10,15,15,5,5,... with pha_ctrl pulsed only once.
- Handshake and collisions:
  - cfg_valid during busy gets cfg_ready=0 and leaves the config unchanged.
  - start+abort in the same cycle gives no sweep.
  - start=stop=20, mode=0, dwell=3 gives 20 for 4 cycles, then done.
- Sync reset mid-sweep: assert rst for 1 cycle at T+5 -> next cycle all outputs at reset values. A following start with no new config gives a 0-frequency single point and done after 1 cycle.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS sweep controller and its dwell timer.
package dds_pkg;

  localparam int W_DEF       = 8;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_REPEAT = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that stops at zero; load wins over decrement.
module dds_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer (single / repeat / triangle) feeding the DDS
// phase accumulator; config via valid/ready, start and abort as strobes.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk_100m,
  input  logic               rst,
  // cfg handshake: a transfer occurs on any cycle where cfg_valid and cfg_ready
  // are both high; cfg_ready is high only in IDLE, and cfg_valid elsewhere is ignored.
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [W-1:0]       cfg_start_frq,
  input  logic [W-1:0]       cfg_stop_frq,
  input  logic [W-1:0]       cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [W-1:0]       cfg_pha,
  input  logic               start,
  input  logic               abort,
  output logic [W-1:0]       frq_ctrl,
  output logic [W-1:0]       pha_ctrl,
  output logic               busy,
  output logic               done,
  output state_t             state
);

  logic [W-1:0]       start_q, stop_q, step_q, pha_q;
  logic [DWELL_W-1:0] dwell_q;
  mode_t              mode_q;

  logic               hs;
  logic [W-1:0]       e_start, e_stop, e_step, e_pha;
  logic [DWELL_W-1:0] e_dwell;
  logic               deg_eff, deg_q, single_like;

  logic               dir_up, last;
  logic               go, zero, tmr_load;
  logic [DWELL_W-1:0] tmr_val;

  logic [W-1:0]       up_base, dn_base, up_val, dn_val;
  logic [W:0]         sum_w, diff_w;
  logic               up_clamp, dn_clamp;

  assign hs = cfg_valid & cfg_ready;

  // A handshake coincident with start supplies the config for that sweep.
  assign e_start = hs ? cfg_start_frq : start_q;
  assign e_stop  = hs ? cfg_stop_frq  : stop_q;
  assign e_step  = hs ? cfg_step      : step_q;
  assign e_pha   = hs ? cfg_pha       : pha_q;
  assign e_dwell = hs ? cfg_dwell     : dwell_q;

  assign deg_eff     = (e_start >= e_stop) || (e_step == '0);
  assign deg_q       = (start_q >= stop_q) || (step_q == '0);
  assign single_like = (mode_q != MODE_REPEAT) && (mode_q != MODE_TRI);

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      pha_q   <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_SINGLE;
    end else if (hs) begin
      start_q <= cfg_start_frq;
      stop_q  <= cfg_stop_frq;
      step_q  <= cfg_step;
      pha_q   <= cfg_pha;
      dwell_q <= cfg_dwell;
      mode_q  <= mode_t'(cfg_mode);
    end
  end

  // Up steps from the current point, or from start when turning at the bottom;
  // down steps from the current point, or from stop when turning at the top.
  always_comb begin
    up_base  = dir_up ? frq_ctrl : start_q;
    dn_base  = dir_up ? stop_q : frq_ctrl;
    sum_w    = {1'b0, up_base} + {1'b0, step_q};
    diff_w   = {1'b0, dn_base} - {1'b0, step_q};
    up_clamp = (sum_w >= {1'b0, stop_q});
    dn_clamp = diff_w[W] || (diff_w[W-1:0] <= start_q);
    up_val   = up_clamp ? stop_q : sum_w[W-1:0];
    dn_val   = dn_clamp ? start_q : diff_w[W-1:0];
  end

  assign go       = (state == IDLE) && start && !abort;
  assign tmr_load = go || ((state == DWELL) && zero);
  assign tmr_val  = go ? e_dwell : dwell_q;

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk_100m),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state == DWELL),
    .zero     (zero)
  );

  always_ff @(posedge clk_100m) begin
    if (rst || abort) begin
      state     <= IDLE;
      frq_ctrl  <= '0;
      pha_ctrl  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
      dir_up    <= 1'b1;
      last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= DWELL;
            frq_ctrl  <= e_start;
            pha_ctrl  <= e_pha;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            dir_up    <= 1'b1;
            last      <= deg_eff;
          end
        end
        DWELL: begin
          pha_ctrl <= '0;
          if (zero) begin
            if (last && dir_up && single_like) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (deg_q) begin
              // Single-point repeat/triangle: hold until abort.
              frq_ctrl <= frq_ctrl;
            end else if (dir_up && !last) begin
              frq_ctrl <= up_val;
              last     <= up_clamp;
            end else if (dir_up) begin
              if (mode_q == MODE_REPEAT) begin
                frq_ctrl <= start_q;
                last     <= 1'b0;
              end else begin
                dir_up   <= 1'b0;
                frq_ctrl <= dn_val;
                last     <= dn_clamp;
              end
            end else if (!last) begin
              frq_ctrl <= dn_val;
              last     <= dn_clamp;
            end else begin
              dir_up   <= 1'b1;
              frq_ctrl <= up_val;
              last     <= up_clamp;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps checked against a
// point-list model built from the sweep rules.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int W       = 8;
  localparam int DWELL_W = 16;

  logic               clk_100m = 1'b0;
  logic               rst, cfg_valid, start, abort;
  logic               cfg_ready, busy, done;
  logic [W-1:0]       cfg_start_frq, cfg_stop_frq, cfg_step, cfg_pha;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic [W-1:0]       frq_ctrl, pha_ctrl;
  state_t             state;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_100m = ~clk_100m;

  dds_sweep_ctrl #(.W(W), .DWELL_W(DWELL_W)) dut (
    .clk_100m      (clk_100m),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_start_frq (cfg_start_frq),
    .cfg_stop_frq  (cfg_stop_frq),
    .cfg_step      (cfg_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_mode      (cfg_mode),
    .cfg_pha       (cfg_pha),
    .start         (start),
    .abort         (abort),
    .frq_ctrl      (frq_ctrl),
    .pha_ctrl      (pha_ctrl),
    .busy          (busy),
    .done          (done),
    .state         (state)
  );

  // Reference: list of sweep points from the rules, each held dw+1 cycles.
  // Single-style modes yield the full trace; others yield n cycles.
  task automatic build_trace(input int s, input int e, input int st, input int dw,
                             input int md, input int n);
    int up[$];
    int pts[$];
    int p;
    bit deg;
    exp_q.delete();
    deg = (s >= e) || (st == 0);
    up.push_back(s);
    if (!deg) begin
      p = s;
      while (p < e) begin
        p = p + st;
        if (p >= e) p = e;
        up.push_back(p);
      end
    end
    pts = up;
    if (!(md == 0 || md == 3)) begin
      while (pts.size() * (dw + 1) < n) begin
        if (deg) begin
          pts.push_back(s);
        end else if (md == 1) begin
          foreach (up[k]) pts.push_back(up[k]);
        end else begin
          p = e;
          while (p > s) begin
            p = p - st;
            if (p <= s) p = s;
            pts.push_back(p);
          end
          for (int k = 1; k < up.size(); k++) pts.push_back(up[k]);
        end
      end
    end
    foreach (pts[k])
      for (int r = 0; r <= dw; r++) exp_q.push_back(pts[k][W-1:0]);
    if (!(md == 0 || md == 3))
      while (exp_q.size() > n) void'(exp_q.pop_back());
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int dw,
                         input int md, input int ph);
    cfg_start_frq = s[W-1:0];
    cfg_stop_frq  = e[W-1:0];
    cfg_step      = st[W-1:0];
    cfg_dwell     = dw[DWELL_W-1:0];
    cfg_mode      = md[1:0];
    cfg_pha       = ph[W-1:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_100m);
    n_tests++;
    if (frq_ctrl !== 8'd0 || pha_ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_ready !== 1'b1 || state !== IDLE) begin
      n_fail++;
      $display("FAIL reset: frq=%0d pha=%0d busy=%b done=%b rdy=%b st=%0d, want 0 0 0 0 1 0",
               frq_ctrl, pha_ctrl, busy, done, cfg_ready, state);
    end
    rst = 1'b0;
  endtask

  // Single-style sweep: full trace, done pulse, return to IDLE.
  task automatic test_single(input string name, input int s, input int e, input int st,
                             input int dw, input int md, input int ph, input bit same);
    int last_v;
    build_trace(s, e, st, dw, md, 0);
    last_v = exp_q[exp_q.size()-1];
    @(negedge clk_100m);
    set_cfg(s, e, st, dw, md, ph);
    cfg_valid = 1'b1;
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cfg_ready idle: got %b want 1", name, cfg_ready);
    end
    if (same) start = 1'b1;
    @(negedge clk_100m);
    cfg_valid = 1'b0;
    if (!same) begin
      start = 1'b1;
      @(negedge clk_100m);
    end
    start = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (frq_ctrl !== exp_q[j] || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s cyc %0d: frq=%0d busy=%b done=%b, want frq=%0d busy=1 done=0",
                 name, j + 1, frq_ctrl, busy, done, exp_q[j]);
      end
      n_tests++;
      if (pha_ctrl !== ((j == 0) ? ph[W-1:0] : 8'd0)) begin
        n_fail++;
        $display("FAIL %s pha cyc %0d: got %0d want %0d", name, j + 1, pha_ctrl,
                 (j == 0) ? ph : 0);
      end
      @(negedge clk_100m);
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || frq_ctrl !== last_v[W-1:0]) begin
      n_fail++;
      $display("FAIL %s done pulse: done=%b busy=%b frq=%0d, want 1 0 %0d",
               name, done, busy, frq_ctrl, last_v);
    end
    @(negedge clk_100m);
    n_tests++;
    if (done !== 1'b0 || cfg_ready !== 1'b1 || frq_ctrl !== last_v[W-1:0] || state !== IDLE) begin
      n_fail++;
      $display("FAIL %s after done: done=%b rdy=%b frq=%0d st=%0d, want 0 1 %0d 0",
               name, done, cfg_ready, frq_ctrl, state, last_v);
    end
  endtask

  // Repeat/triangle: n cycles, a stray start midway, then abort.
  task automatic test_continuous(input string name, input int s, input int e, input int st,
                                 input int dw, input int md, input int ph, input int n);
    build_trace(s, e, st, dw, md, n);
    @(negedge clk_100m);
    set_cfg(s, e, st, dw, md, ph);
    cfg_valid = 1'b1;
    @(negedge clk_100m);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk_100m);
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      n_tests++;
      if (frq_ctrl !== exp_q[j] || busy !== 1'b1 || done !== 1'b0 ||
          pha_ctrl !== ((j == 0) ? ph[W-1:0] : 8'd0)) begin
        n_fail++;
        $display("FAIL %s cyc %0d: frq=%0d pha=%0d busy=%b done=%b, want frq=%0d busy=1 done=0",
                 name, j + 1, frq_ctrl, pha_ctrl, busy, done, exp_q[j]);
      end
      start = (j == 5);
      @(negedge clk_100m);
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk_100m);
    abort = 1'b0;
    n_tests++;
    if (frq_ctrl !== 8'd0 || pha_ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s abort: frq=%0d pha=%0d busy=%b done=%b rdy=%b, want 0 0 0 0 1",
               name, frq_ctrl, pha_ctrl, busy, done, cfg_ready);
    end
  endtask

  task automatic test_handshake();
    build_trace(10, 40, 10, 1, 1, 8);
    @(negedge clk_100m);
    set_cfg(10, 40, 10, 1, 1, 33);
    cfg_valid = 1'b1;
    @(negedge clk_100m);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk_100m);
    start = 1'b0;
    set_cfg(100, 200, 7, 0, 0, 99);
    cfg_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_tests++;
      if (cfg_ready !== 1'b0 || frq_ctrl !== exp_q[j]) begin
        n_fail++;
        $display("FAIL hs_busy cyc %0d: rdy=%b frq=%0d, want rdy=0 frq=%0d",
                 j + 1, cfg_ready, frq_ctrl, exp_q[j]);
      end
      @(negedge clk_100m);
    end
    cfg_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk_100m);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk_100m);
    start = 1'b0;
    n_tests++;
    if (frq_ctrl !== 8'd10 || pha_ctrl !== 8'd33 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_retained: frq=%0d pha=%0d busy=%b, want 10 33 1",
               frq_ctrl, pha_ctrl, busy);
    end
    abort = 1'b1;
    @(negedge clk_100m);
    abort = 1'b0;
  endtask

  task automatic test_start_abort();
    @(negedge clk_100m);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_100m);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) begin
      n_tests++;
      if (busy !== 1'b0 || frq_ctrl !== 8'd0 || state !== IDLE) begin
        n_fail++;
        $display("FAIL start_abort: busy=%b frq=%0d st=%0d, want 0 0 0", busy, frq_ctrl, state);
      end
      @(negedge clk_100m);
    end
  endtask

  task automatic test_mid_reset();
    build_trace(10, 40, 10, 2, 0, 0);
    @(negedge clk_100m);
    set_cfg(10, 40, 10, 2, 0, 64);
    cfg_valid = 1'b1;
    @(negedge clk_100m);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk_100m);
    start = 1'b0;
    repeat (4) @(negedge clk_100m);
    n_tests++;
    if (frq_ctrl !== exp_q[4] || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_pre: frq=%0d busy=%b, want %0d 1", frq_ctrl, busy, exp_q[4]);
    end
    rst = 1'b1;
    @(negedge clk_100m);
    rst = 1'b0;
    n_tests++;
    if (frq_ctrl !== 8'd0 || pha_ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_ready !== 1'b1 || state !== IDLE) begin
      n_fail++;
      $display("FAIL mrst_vals: frq=%0d pha=%0d busy=%b done=%b rdy=%b, want 0 0 0 0 1",
               frq_ctrl, pha_ctrl, busy, done, cfg_ready);
    end
    start = 1'b1;
    @(negedge clk_100m);
    start = 1'b0;
    n_tests++;
    if (frq_ctrl !== 8'd0 || pha_ctrl !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_point: frq=%0d pha=%0d busy=%b done=%b, want 0 0 1 0",
               frq_ctrl, pha_ctrl, busy, done);
    end
    @(negedge clk_100m);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_done: done=%b busy=%b, want 1 0", done, busy);
    end
    @(negedge clk_100m);
  endtask

  initial begin
    int s, e, st, dw;
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single("single", 10, 40, 10, 2, 0, 64, 1'b0);
    test_single("clamp", 250, 255, 4, 0, 0, 5, 1'b0);
    test_single("degen", 20, 20, 3, 3, 0, 7, 1'b0);
    test_single("rsvd_same", 30, 90, 25, 1, 3, 200, 1'b1);
    test_continuous("tri", 10, 30, 10, 0, 2, 17, 30);
    test_continuous("repeat", 5, 15, 5, 1, 1, 64, 24);
    test_continuous("tri_degen", 50, 20, 3, 1, 2, 9, 12);
    test_continuous("tri_borrow", 2, 7, 10, 0, 2, 1, 12);
    for (int i = 0; i < 4; i++) begin
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = $urandom_range(0, 40);
      dw = $urandom_range(0, 3);
      test_single("rand_single", s, e, st, dw, (i % 2 == 1) ? 3 : 0,
                  $urandom_range(0, 255), (i % 2 == 1));
    end
    for (int i = 0; i < 4; i++) begin
      s  = $urandom_range(0, 200);
      e  = $urandom_range(0, 255);
      st = $urandom_range(1, 60);
      dw = $urandom_range(0, 2);
      test_continuous("rand_cont", s, e, st, dw, (i % 2 == 1) ? 2 : 1,
                      $urandom_range(0, 255), 60);
    end
    test_handshake();
    test_start_abort();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
